sock_bus_arbiter: RTL
=====================

Name: sock_bus_arbiter

Overview:
- Round-robin arbiter and transaction sequencer that shares one register-bus master between NREQ DPI-socket command channels.
- Each channel presents a single read/write command. The block grants one channel at a time, runs the bus handshake with a timeout, and returns the response to the granted channel.
- It sits between the socket-driven stimulus channels and the DUT register bus, clocked by the clkGen clock/reset.

Parameters:
- NREQ, 4: number of requester channels (2..8).
- AW, 16: bus address width.
- DW, 32: bus data width.
- TIMEOUT, 255: maximum BUS-state cycles before abort (1..65535); counter width is clog2(TIMEOUT+1).

Ports:
- clk  in  1  system clock, rising edge.
- rstn  in  1  asynchronous active-low reset.
- req_valid  in  NREQ  per-channel command valid.
- req_ready  out  NREQ  per-channel command accept (one-hot or zero).
- req_write  in  NREQ  per-channel 1=write, 0=read.
- req_addr  in  NREQ*AW  packed addresses; channel i at [i*AW +: AW].
- req_wdata  in  NREQ*DW  packed write data; channel i at [i*DW +: DW].
- rsp_valid  out  NREQ  one-cycle response pulse to the granted channel.
- rsp_rdata  out  DW  read data (0 for writes and for timeouts).
- rsp_err  out  1  1 = timeout abort; qualified by any rsp_valid bit.
- bus_req  out  1  bus transaction request, held until ack or timeout.
- bus_write  out  1  bus direction.
- bus_addr  out  AW  bus address.
- bus_wdata  out  DW  bus write data.
- bus_ack  in  1  bus completion; single-cycle pulse.
- bus_rdata  in  DW  read data, valid with bus_ack.
- busy  out  1  high in any state other than IDLE.
- grant_id  out  clog2(NREQ)  index of the current or last granted channel.

Behaviour:
- Reset (rstn=0, async): state=IDLE.
  - All outputs 0: req_ready, rsp_valid, rsp_rdata, rsp_err, bus_req, bus_write, bus_addr, bus_wdata, busy, grant_id.
  - last_grant=NREQ-1, so channel 0 has first priority.
  - Reset asserted mid-transaction aborts it: no response is issued and bus_req drops immediately.
- FSM states: IDLE, BUS, RESP.
- IDLE:
  - Winner = first i with req_valid[i]=1, scanning from (last_grant+1) mod NREQ upward with wrap.
  - req_ready[winner]=1 combinationally in this cycle only. A handshake occurs when valid and ready are both 1.
  - On that clock edge: capture write/addr/wdata into bus_* registers, set grant_id=winner, clear the timeout counter, go to BUS.
  - No valid request: stay in IDLE.
- BUS:
  - bus_req=1 and the bus_* fields are stable; the counter increments each cycle.
  - bus_ack=1: capture rdata (bus_rdata if read, 0 if write), set rsp_err=0, go to RESP.
  - Otherwise, if counter==TIMEOUT-1: set rsp_rdata=0, rsp_err=1, go to RESP. Ack wins if it coincides with the timeout cycle.
- RESP:
  - rsp_valid[grant_id]=1 for exactly one cycle; bus_req=0.
  - last_grant=grant_id; go to IDLE.
  - rsp_rdata and rsp_err hold their values until the next RESP.
- Latency:
  - Accept at cycle 0; bus_req high from cycle 1.
  - Ack in BUS cycle k (k≥1) gives rsp_valid in cycle k+1.
  - Minimum 3 cycles per transaction; no back-to-back grants without an IDLE cycle.
- bus_ack outside BUS is ignored. req_valid deasserted before grant is legal: that channel is simply skipped.
- busy=1 in BUS and RESP; req_ready is all-zero outside IDLE.
- Fairness: with all channels continuously valid, grants rotate 0,1,…,NREQ-1,0. No channel waits more than NREQ transactions.

Test Plan:
- Reset then single read: ch2 valid, addr=0x0010. Bus acks 2 cycles after bus_req with rdata=0xDEADBEEF → rsp_valid=4'b0100, rsp_rdata=0xDEADBEEF, rsp_err=0, grant_id=2.
- Round-robin: all 4 channels continuously valid, writes acked immediately → grant order 0,1,2,3,0. Each rsp_valid pulse is one-hot and matches grant_id. Transaction period is 3 cycles.
- Timeout: TIMEOUT=8, ch1 read, bus_ack never asserted → bus_req high for exactly 8 cycles, then rsp_valid=4'b0010, rsp_err=1, rsp_rdata=0.
- Ack on the final timeout cycle, and a stray bus_ack pulsed in IDLE → the coincident ack completes with rsp_err=0; the stray ack causes no state change.
- Reset mid-BUS: ch3 write outstanding, rstn pulsed low → bus_req=0 and busy=0 immediately, no rsp_valid. After release, ch0 and ch3 both valid → ch0 granted first.
- Requester withdrawal: ch1 and ch2 valid with last_grant=0, ch1 drops valid before its grant → ch2 granted, req_ready[1] never asserted.

Source files
------------

// File: rtl/sock_bus_arbiter.sv
//-----------------------------------------------------------------------------
// sock_bus_arbiter
//
// Round-robin arbiter and transaction sequencer. It shares one register-bus
// master between NREQ socket command channels. One channel is granted at a
// time. Its command is driven onto the bus, and a timeout guards the
// handshake. The response goes back to the granted channel as a one-cycle
// pulse.
//
// Ports
//   clk        system clock, rising edge
//   rstn       asynchronous active-low reset
//   req_valid  per-channel command valid
//   req_ready  per-channel command accept (one-hot or zero, IDLE only)
//   req_write  per-channel direction, 1 = write
//   req_addr   packed addresses, channel i at [i*AW +: AW]
//   req_wdata  packed write data, channel i at [i*DW +: DW]
//   rsp_valid  one-cycle response pulse to the granted channel
//   rsp_rdata  read data (0 for writes and timeouts), held until next response
//   rsp_err    1 = transaction aborted by timeout
//   bus_req    bus request, held until ack or timeout
//   bus_write  bus direction
//   bus_addr   bus address
//   bus_wdata  bus write data
//   bus_ack    bus completion pulse
//   bus_rdata  bus read data, valid with bus_ack
//   busy       high whenever not IDLE
//   grant_id   index of the current or last granted channel
//-----------------------------------------------------------------------------
`timescale 1ns/1ps
module sock_bus_arbiter #(
   parameter int NREQ    = 4,
   parameter int AW      = 16,
   parameter int DW      = 32,
   parameter int TIMEOUT = 255
) (
   input  logic                     clk,
   input  logic                     rstn,
   input  logic [NREQ-1:0]          req_valid,
   output logic [NREQ-1:0]          req_ready,
   input  logic [NREQ-1:0]          req_write,
   input  logic [NREQ*AW-1:0]       req_addr,
   input  logic [NREQ*DW-1:0]       req_wdata,
   output logic [NREQ-1:0]          rsp_valid,
   output logic [DW-1:0]            rsp_rdata,
   output logic                     rsp_err,
   output logic                     bus_req,
   output logic                     bus_write,
   output logic [AW-1:0]            bus_addr,
   output logic [DW-1:0]            bus_wdata,
   input  logic                     bus_ack,
   input  logic [DW-1:0]            bus_rdata,
   output logic                     busy,
   output logic [$clog2(NREQ)-1:0]  grant_id
);

   localparam int GW = $clog2(NREQ);
   localparam int CW = $clog2(TIMEOUT + 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_BUS  = 2'd1;
   localparam logic [1:0] S_RESP = 2'd2;

   logic [1:0]    state_q, state_d;
   logic [GW-1:0] last_grant_q, last_grant_d;
   logic [GW-1:0] grant_q, grant_d;
   logic          bus_write_q, bus_write_d;
   logic [AW-1:0] bus_addr_q, bus_addr_d;
   logic [DW-1:0] bus_wdata_q, bus_wdata_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [DW-1:0] rdata_q, rdata_d;
   logic          err_q, err_d;

   logic [GW-1:0] winner;
   logic          found;
   logic [GW:0]   scan_idx;

   // Rotating priority scan: start one past the last grant and wrap, so the
   // channel just served has the lowest priority in the next arbitration.
   always_comb begin
      winner   = '0;
      found    = 1'b0;
      scan_idx = '0;
      for (int k = 1; k <= NREQ; k++) begin
         scan_idx = {1'b0, last_grant_q} + (GW+1)'(k);
         if (scan_idx >= (GW+1)'(NREQ)) begin
            scan_idx = scan_idx - (GW+1)'(NREQ);
         end
         if (!found && req_valid[scan_idx[GW-1:0]]) begin
            found  = 1'b1;
            winner = scan_idx[GW-1:0];
         end
      end
   end

   // req_ready is combinational, so it is also gated by rstn. This keeps
   // every output low while reset is held.
   always_comb begin
      req_ready = '0;
      if (rstn && (state_q == S_IDLE) && found) begin
         req_ready[winner] = 1'b1;
      end
   end

   always_comb begin
      rsp_valid = '0;
      if (state_q == S_RESP) begin
         rsp_valid[grant_q] = 1'b1;
      end
   end

   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      grant_d      = grant_q;
      bus_write_d  = bus_write_q;
      bus_addr_d   = bus_addr_q;
      bus_wdata_d  = bus_wdata_q;
      cnt_d        = cnt_q;
      rdata_d      = rdata_q;
      err_d        = err_q;
      case (state_q)
         S_IDLE: begin
            if (found) begin
               grant_d     = winner;
               bus_write_d = req_write[winner];
               bus_addr_d  = req_addr[32'(winner)*AW +: AW];
               bus_wdata_d = req_wdata[32'(winner)*DW +: DW];
               cnt_d       = '0;
               state_d     = S_BUS;
            end
         end
         S_BUS: begin
            cnt_d = cnt_q + CW'(1);
            // An ack takes priority over the timeout when both land in the same cycle.
            if (bus_ack) begin
               rdata_d = bus_write_q ? '0 : bus_rdata;
               err_d   = 1'b0;
               state_d = S_RESP;
            end else if (cnt_q == CW'(TIMEOUT - 1)) begin
               rdata_d = '0;
               err_d   = 1'b1;
               state_d = S_RESP;
            end
         end
         S_RESP: begin
            last_grant_d = grant_q;
            state_d      = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q      <= S_IDLE;
         last_grant_q <= GW'(NREQ - 1);
         grant_q      <= '0;
         bus_write_q  <= 1'b0;
         bus_addr_q   <= '0;
         bus_wdata_q  <= '0;
         cnt_q        <= '0;
         rdata_q      <= '0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         grant_q      <= grant_d;
         bus_write_q  <= bus_write_d;
         bus_addr_q   <= bus_addr_d;
         bus_wdata_q  <= bus_wdata_d;
         cnt_q        <= cnt_d;
         rdata_q      <= rdata_d;
         err_q        <= err_d;
      end
   end

   // bus_req is decoded from the state, so an asynchronous reset drops it at once.
   assign bus_req   = (state_q == S_BUS);
   assign busy      = (state_q != S_IDLE);
   assign bus_write = bus_write_q;
   assign bus_addr  = bus_addr_q;
   assign bus_wdata = bus_wdata_q;
   assign rsp_rdata = rdata_q;
   assign rsp_err   = err_q;
   assign grant_id  = grant_q;

endmodule
